// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer with a held output word and a valid/ready handshake.
// Optional trailing even-parity bit per word when PARITY_CHECK_EN is defined.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       serial_in,
    input  logic                       shift,
    input  logic                       clear,
    output logic [WIDTH-1:0]           parallel_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overrun,
    output logic                       parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PARITY  = 2'd2
    } state_t;

    // Odd total ones across data plus the even-parity bit means a corrupted word.
    function automatic logic parity_mismatch(input logic [WIDTH-1:0] data, input logic pbit);
        return ^{data, pbit};
    endfunction
`else
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  pout_q, pout_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              perr_q, perr_d;

    logic [WIDTH-1:0]  shifted_s;
    logic              complete_s;
    logic [WIDTH-1:0]  word_s;
    logic              word_perr_s;

    // Shift-register input path: direction chosen by bit order.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_s = {shreg_q[WIDTH-2:0], serial_in};
        end else begin
            shifted_s = {serial_in, shreg_q[WIDTH-1:1]};
        end
    end

    // Next-state logic: bit collection FSM, completion, handshake and overrun tracking.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        pout_d      = pout_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        perr_d      = perr_q;
        complete_s  = 1'b0;
        word_s      = shifted_s;
        word_perr_s = 1'b0;

        if (clear) begin
            state_d   = ST_IDLE;
            shreg_d   = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (shift) begin
            case (state_q)
                ST_IDLE, ST_COLLECT: begin
                    shreg_d = shifted_s;
                    if (cnt_q == CNT_LAST) begin
`ifdef PARITY_CHECK_EN
                        cnt_d   = CNT_FULL;
                        state_d = ST_PARITY;
`else
                        complete_s = 1'b1;
                        word_s     = shifted_s;
                        shreg_d    = '0;
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
`endif
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = ST_COLLECT;
                    end
                end
`ifdef PARITY_CHECK_EN
                ST_PARITY: begin
                    complete_s  = 1'b1;
                    word_s      = shreg_q;
                    word_perr_s = parity_mismatch(shreg_q, serial_in);
                    shreg_d     = '0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // A word finishing while the consumer is still holding off is dropped, not queued.
        if (complete_s) begin
            if (!valid_q || out_ready) begin
                pout_d  = word_s;
                perr_d  = word_perr_s;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            pout_d = pout_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            pout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            pout_q    <= pout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    assign parallel_out = pout_q;
    assign out_valid    = valid_q;
    assign bit_count    = cnt_q;
    assign overrun      = overrun_q;
`ifdef PARITY_CHECK_EN
    assign parity_err   = perr_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: one MSB-first and one LSB-first instance share stimulus.
module tb_sipo_deserializer;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          serial_in = 1'b0;
    logic          shift = 1'b0;
    logic          clear = 1'b0;
    logic          out_ready = 1'b0;

    logic [W-1:0]  pout_m, pout_l;
    logic          valid_m, valid_l;
    logic [CW-1:0] cnt_m, cnt_l;
    logic          ovr_m, ovr_l;
    logic          perr_m, perr_l;

    typedef struct {
        logic [W-1:0] word_m;
        logic [W-1:0] word_l;
        logic         perr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clock(clock), .reset_n(reset_n), .serial_in(serial_in), .shift(shift),
        .clear(clear), .parallel_out(pout_m), .out_valid(valid_m), .out_ready(out_ready),
        .bit_count(cnt_m), .overrun(ovr_m), .parity_err(perr_m)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clock(clock), .reset_n(reset_n), .serial_in(serial_in), .shift(shift),
        .clear(clear), .parallel_out(pout_l), .out_valid(valid_l), .out_ready(out_ready),
        .bit_count(cnt_l), .overrun(ovr_l), .parity_err(perr_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rev4(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    // Called at a falling edge: drive inputs, score any word accepted at the coming edge, advance one clock.
    task automatic cycle(input logic sh, input logic bit_in, input logic clr, input logic rdy);
        exp_t e;
        shift     = sh;
        serial_in = bit_in;
        clear     = clr;
        out_ready = rdy;
        if (valid_m && rdy) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_word", 32'(pout_m), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_word_msb", 32'(pout_m), 32'(e.word_m));
                check_eq("sb_word_lsb", 32'(pout_l), 32'(e.word_l));
                check_eq("sb_valid_lsb", 32'(valid_l), 32'd1);
                check_eq("sb_parity_err", 32'(perr_m), 32'(e.perr));
            end
        end
        @(posedge clock);
        @(negedge clock);
        shift = 1'b0;
        clear = 1'b0;
    endtask

    // seq[W-1] is the first bit on the wire; rdy_last applies to the completing cycle.
    task automatic send_word(input logic [W-1:0] seq, input logic pbit, input logic rdy,
                             input logic rdy_last, input logic push);
        logic r;
        exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            r = rdy;
`ifndef PARITY_CHECK_EN
            if (i == 0) r = rdy_last;
`endif
            cycle(1'b1, seq[i], 1'b0, r);
        end
`ifdef PARITY_CHECK_EN
        cycle(1'b1, pbit, 1'b0, rdy_last);
        e.perr = (^seq) ^ pbit;
`else
        e.perr = 1'b0;
`endif
        e.word_m = seq;
        e.word_l = rev4(seq);
        if (push) sb_q.push_back(e);
    endtask

    initial begin
        logic [W-1:0] seq;

        // Reset values
        repeat (2) @(negedge clock);
        check_eq("rst_pout_m", 32'(pout_m), 32'd0);
        check_eq("rst_valid_m", 32'(valid_m), 32'd0);
        check_eq("rst_cnt_m", 32'(cnt_m), 32'd0);
        check_eq("rst_ovr_m", 32'(ovr_m), 32'd0);
        check_eq("rst_perr_m", 32'(perr_m), 32'd0);
        check_eq("rst_pout_l", 32'(pout_l), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // 1,0,1,1 with consumer stalled: check latency and placement
        seq = 4'b1011;
        for (int i = W - 1; i >= 1; i--) cycle(1'b1, seq[i], 1'b0, 1'b0);
        check_eq("t1_cnt_3", 32'(cnt_m), 32'd3);
        check_eq("t1_valid_early", 32'(valid_m), 32'd0);
        cycle(1'b1, seq[0], 1'b0, 1'b0);
`ifdef PARITY_CHECK_EN
        check_eq("t1_valid_before_par", 32'(valid_m), 32'd0);
        check_eq("t1_cnt_hold", 32'(cnt_m), 32'd4);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
`endif
        check_eq("t1_valid", 32'(valid_m), 32'd1);
        check_eq("t1_cnt_0", 32'(cnt_m), 32'd0);
        check_eq("t1_pout_msb", 32'(pout_m), 32'hB);
        check_eq("t1_pout_lsb", 32'(pout_l), 32'hD);
        check_eq("t1_perr", 32'(perr_m), 32'd0);
        sb_q.push_back('{4'hB, 4'hD, 1'b0});
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t1_hold_valid", 32'(valid_m), 32'd1);
        check_eq("t1_hold_pout", 32'(pout_m), 32'hB);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t1_valid_drop", 32'(valid_m), 32'd0);

        // Overrun: A held, 5 dropped
        send_word(4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("ovr_hold_pout", 32'(pout_m), 32'hA);
        check_eq("ovr_set", 32'(ovr_m), 32'd1);
        check_eq("ovr_set_l", 32'(ovr_l), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("ovr_valid_drop", 32'(valid_m), 32'd0);
        check_eq("ovr_sticky", 32'(ovr_m), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("ovr_cleared", 32'(ovr_m), 32'd0);

        // out_ready tied high, back-to-back C then 6
        send_word(4'hC, 1'b0, 1'b1, 1'b1, 1'b1);
        send_word(4'h6, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("b2b_ovr", 32'(ovr_m), 32'd0);

        // Completion on the same edge as handshake of the held word
        send_word(4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(4'h9, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("same_edge_valid", 32'(valid_m), 32'd1);
        check_eq("same_edge_pout", 32'(pout_m), 32'h9);
        check_eq("same_edge_ovr", 32'(ovr_m), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("same_edge_drain", 32'(valid_m), 32'd0);

        // Clear wins over a simultaneous shift, then a clean word
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("clr_cnt", 32'(cnt_m), 32'd0);
        check_eq("clr_valid", 32'(valid_m), 32'd0);
        send_word(4'h5, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("clr_word_pout", 32'(pout_m), 32'h5);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef PARITY_CHECK_EN
        // Bad parity is still delivered, flagged
        send_word(4'b1011, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("par_bad_valid", 32'(valid_m), 32'd1);
        check_eq("par_bad_err", 32'(perr_m), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Asynchronous reset with a held word and a partial word
        send_word(4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("pre_rst_cnt", 32'(cnt_m), 32'd3);
        reset_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(valid_m), 32'd0);
        check_eq("arst_pout", 32'(pout_m), 32'd0);
        check_eq("arst_cnt", 32'(cnt_m), 32'd0);
        check_eq("arst_ovr", 32'(ovr_m), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        check_eq("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
